// File: rtl/playback_control.sv
// Playback sequencer: button edges and track_end pulses into track select and timer/address control.
// Optional PLAYBACK_AUTO_ADVANCE_EN: track_end in PLAY advances to the next track instead of stopping.
//
// state | meaning
// STOP  | idle, timer held, waiting for play
// PLAY  | timer counting, samples streaming
// PAUSE | timer held, position kept
// LOAD  | one-cycle track change, resets timer and address, then goes to target
module playback_control #(
    parameter int N_TRACKS    = 4,
    parameter int RESTART_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play_pause,
    input  logic       next,
    input  logic       prev,
    input  logic       track_end,
    input  logic [3:0] seconds0,
    input  logic [3:0] seconds1,
    input  logic [3:0] minutes0,
    output logic [3:0] music,
    output logic       timer_count,
    output logic       timer_reset,
    output logic       addr_reset,
    output logic       playing,
    output logic       track_changed
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LOAD  = 2'd3;

    localparam logic [3:0] LAST_TRACK = 4'(N_TRACKS - 1);
    localparam logic [3:0] RESTART_TH = 4'(RESTART_SEC);

    logic [1:0] state, state_nx;
    logic [1:0] target, target_nx;
    logic [3:0] music_nx;
    logic       play_pause_q, next_q, prev_q;
    logic       pp_edge, next_edge, prev_edge;
    logic [3:0] music_inc, music_dec, music_prev;
    logic       restart;

    assign pp_edge   = play_pause & ~play_pause_q;
    assign next_edge = next & ~next_q;
    assign prev_edge = prev & ~prev_q;

    assign music_inc  = (music == LAST_TRACK) ? 4'd0 : music + 4'd1;
    assign music_dec  = (music == 4'd0) ? LAST_TRACK : music - 4'd1;
    assign restart    = (minutes0 != 4'd0) || (seconds1 != 4'd0) || (seconds0 >= RESTART_TH);
    assign music_prev = restart ? music : music_dec;

    always_comb begin
        state_nx  = state;
        target_nx = target;
        music_nx  = music;
        case (state)
            ST_STOP: begin
                if (next_edge) begin
                    music_nx  = music_inc;
                    state_nx  = ST_LOAD;
                    target_nx = ST_STOP;
                end else if (prev_edge) begin
                    music_nx  = music_dec;
                    state_nx  = ST_LOAD;
                    target_nx = ST_STOP;
                end else if (pp_edge) begin
                    state_nx  = ST_LOAD;
                    target_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (track_end) begin
                    state_nx = ST_LOAD;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
                    if (music == LAST_TRACK) begin
                        music_nx  = 4'd0;
                        target_nx = ST_STOP;
                    end else begin
                        music_nx  = music + 4'd1;
                        target_nx = ST_PLAY;
                    end
`else
                    target_nx = ST_STOP;
`endif
                end else if (next_edge) begin
                    music_nx  = music_inc;
                    state_nx  = ST_LOAD;
                    target_nx = ST_PLAY;
                end else if (prev_edge) begin
                    music_nx  = music_prev;
                    state_nx  = ST_LOAD;
                    target_nx = ST_PLAY;
                end else if (pp_edge) begin
                    state_nx = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (next_edge) begin
                    music_nx  = music_inc;
                    state_nx  = ST_LOAD;
                    target_nx = ST_PAUSE;
                end else if (prev_edge) begin
                    music_nx  = music_prev;
                    state_nx  = ST_LOAD;
                    target_nx = ST_PAUSE;
                end else if (pp_edge) begin
                    state_nx = ST_PLAY;
                end
            end
            default: state_nx = target;
        endcase
    end

    // Edge registers reset high so a button held across reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_STOP;
            target       <= ST_STOP;
            music        <= 4'd0;
            play_pause_q <= 1'b1;
            next_q       <= 1'b1;
            prev_q       <= 1'b1;
        end else begin
            state        <= state_nx;
            target       <= target_nx;
            music        <= music_nx;
            play_pause_q <= play_pause;
            next_q       <= next;
            prev_q       <= prev;
        end
    end

    assign playing       = (state == ST_PLAY);
    assign timer_count   = playing;
    assign track_changed = (state == ST_LOAD);
    assign timer_reset   = track_changed;
    assign addr_reset    = track_changed;

endmodule

// File: tb/tb_playback_control.sv
// Self-checking bench for playback_control: directed scenarios plus randomized buttons,
// checked every cycle against a behavioural model of the player.
module tb_playback_control;

    localparam int N_TRACKS    = 4;
    localparam int RESTART_SEC = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play_pause = 1'b0, next = 1'b0, prev = 1'b0, track_end = 1'b0;
    logic [3:0] seconds0 = 4'd0, seconds1 = 4'd0, minutes0 = 4'd0;
    logic [3:0] music;
    logic       timer_count, timer_reset, addr_reset, playing, track_changed;

    playback_control #(.N_TRACKS(N_TRACKS), .RESTART_SEC(RESTART_SEC)) dut (
        .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
        .track_end(track_end), .seconds0(seconds0), .seconds1(seconds1), .minutes0(minutes0),
        .music(music), .timer_count(timer_count), .timer_reset(timer_reset),
        .addr_reset(addr_reset), .playing(playing), .track_changed(track_changed)
    );

    always #5 clk = ~clk;

    // Model: the player's resting mode (0 stopped, 1 running, 2 paused) plus a pending track load.
    int m_music, m_mode, m_after;
    bit m_loading;
    bit lv_pp, lv_nx, lv_pv;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_music = 0; m_mode = 0; m_after = 0; m_loading = 0;
            lv_pp = 1; lv_nx = 1; lv_pv = 1;
        end else begin
            bit e_pp, e_nx, e_pv;
            int elapsed;
            e_pp = play_pause && !lv_pp;
            e_nx = next && !lv_nx;
            e_pv = prev && !lv_pv;
            lv_pp = play_pause; lv_nx = next; lv_pv = prev;
            elapsed = 60 * int'(minutes0) + 10 * int'(seconds1) + int'(seconds0);
            if (m_loading) begin
                m_loading = 0;
                m_mode = m_after;
            end else if (m_mode == 1 && track_end) begin
                m_loading = 1;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
                if (m_music + 1 < N_TRACKS) begin m_music = m_music + 1; m_after = 1; end
                else begin m_music = 0; m_after = 0; end
`else
                m_after = 0;
`endif
            end else if (e_nx) begin
                m_music = (m_music + 1) % N_TRACKS;
                m_loading = 1; m_after = m_mode;
            end else if (e_pv) begin
                if (m_mode == 0 || elapsed < RESTART_SEC)
                    m_music = (m_music + N_TRACKS - 1) % N_TRACKS;
                m_loading = 1; m_after = m_mode;
            end else if (e_pp) begin
                if (m_mode == 0) begin m_loading = 1; m_after = 1; end
                else m_mode = (m_mode == 1) ? 2 : 1;
            end
        end
    end

    int    n_tests = 0, n_fail = 0;
    bit    lit_valid = 0;
    string lit_name;
    int    lit_music;
    bit    lit_play, lit_pulse;

    always @(negedge clk) begin
        logic [8:0] got, exp_v;
        bit         mp, ml;
        mp = !m_loading && m_mode == 1 && reset;
        ml = m_loading && reset;
        exp_v = {4'(m_music), mp, mp, ml, ml, ml};
        got   = {music, timer_count, playing, timer_reset, addr_reset, track_changed};
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, got, exp_v);
        end
        if (lit_valid) begin
            logic [8:0] lexp, mgot;
            lexp = {4'(lit_music), lit_play, lit_play, lit_pulse, lit_pulse, lit_pulse};
            mgot = exp_v;
            n_tests++;
            if (got !== lexp) begin
                n_fail++;
                $display("FAIL %s dut got=%b expected=%b", lit_name, got, lexp);
            end
            n_tests++;
            if (mgot !== lexp) begin
                n_fail++;
                $display("FAIL %s model got=%b expected=%b", lit_name, mgot, lexp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic lit(input string name, input int m, input bit pl, input bit pu);
        lit_name = name; lit_music = m; lit_play = pl; lit_pulse = pu;
        lit_valid = 1;
        @(negedge clk); #1;
        lit_valid = 0;
    endtask

    task automatic pulse_next();
        next = 1; cyc(1); next = 0; cyc(1);
    endtask

    initial begin
        cyc(3);
        lit("reset_state", 0, 0, 0);
        reset = 1; cyc(1);

        // play held for 25 cycles: one load, then steady play
        play_pause = 1; cyc(1);
        lit("pp_load", 0, 0, 1);
        cyc(1);
        lit("pp_play", 0, 1, 0);
        cyc(23);
        lit("pp_held", 0, 1, 0);
        play_pause = 0; cyc(1);

        repeat (3) pulse_next();
        lit("play_m3", 3, 1, 0);
        next = 1; cyc(1);
        lit("next_wrap_load", 0, 0, 1);
        next = 0; cyc(1);
        lit("next_wrap_play", 0, 1, 0);
        play_pause = 1; cyc(1);
        lit("pause", 0, 0, 0);
        play_pause = 0; cyc(1);
        play_pause = 1; cyc(1); play_pause = 0; cyc(1);
        pulse_next();
        lit("play_m1", 1, 1, 0);

        seconds0 = 4'd5;
        prev = 1; cyc(1);
        lit("prev_restart", 1, 0, 1);
        prev = 0; cyc(1);
        seconds0 = 4'd2;
        prev = 1; cyc(1);
        lit("prev_back", 0, 0, 1);
        prev = 0; cyc(1);
        seconds0 = 4'd0;
        prev = 1; cyc(1);
        lit("prev_wrap", 3, 0, 1);
        prev = 0; cyc(1);
        lit("play_m3_again", 3, 1, 0);

        track_end = 1; cyc(1); track_end = 0;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
        lit("tend_last_load", 0, 0, 1);
        cyc(1);
        lit("tend_last_stop", 0, 0, 0);
        play_pause = 1; cyc(1); play_pause = 0; cyc(1);
        pulse_next();
        track_end = 1; cyc(1); track_end = 0;
        lit("tend_mid_load", 2, 0, 1);
        cyc(1);
        lit("tend_mid_play", 2, 1, 0);
`else
        lit("tend_load", 3, 0, 1);
        cyc(1);
        lit("tend_stop", 3, 0, 0);
        play_pause = 1; cyc(1); play_pause = 0; cyc(1);
        repeat (2) pulse_next();
        track_end = 1; cyc(1); track_end = 0;
        lit("tend_m1_load", 1, 0, 1);
        cyc(1);
        lit("tend_m1_stop", 1, 0, 0);
`endif

        // fresh start at music 0, then simultaneous events
        reset = 0; cyc(1); reset = 1; cyc(1);
        play_pause = 1; cyc(1); play_pause = 0; cyc(1);
        track_end = 1; next = 1; play_pause = 1; cyc(1);
        track_end = 0;
`ifdef PLAYBACK_AUTO_ADVANCE_EN
        lit("combo_load", 1, 0, 1);
        cyc(1);
        lit("combo_play", 1, 1, 0);
`else
        lit("combo_load", 0, 0, 1);
        cyc(1);
        lit("combo_stop", 0, 0, 0);
`endif
        next = 0; play_pause = 0; cyc(1);
        prev = 1; cyc(1);
        prev = 0; next = 1; cyc(1);
`ifdef PLAYBACK_AUTO_ADVANCE_EN
        lit("next_in_load", 0, 1, 0);
`else
        lit("next_in_load", 3, 0, 0);
`endif
        next = 0; cyc(1);

        // reset during a load, button held across release
        next = 1; cyc(1);
        play_pause = 1; next = 0;
        reset = 0; #1;
        lit("rst_mid_load", 0, 0, 0);
        cyc(2); reset = 1;
        cyc(5);
        lit("rst_held_release", 0, 0, 0);
        play_pause = 0; cyc(1);

        for (int i = 0; i < 4000; i++) begin
            play_pause = ($urandom_range(0, 3) == 0);
            next       = ($urandom_range(0, 5) == 0);
            prev       = ($urandom_range(0, 5) == 0);
            track_end  = ($urandom_range(0, 7) == 0);
            seconds0   = 4'($urandom_range(0, 9));
            seconds1   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 5)) : 4'd0;
            minutes0   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 9)) : 4'd0;
            if ($urandom_range(0, 499) == 0) reset = 0;
            else reset = 1;
            cyc(1);
        end
        reset = 1; cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/playback_control.md
# playback_control

Sequencing controller for the music player's playback datapath. It turns play/pause, next and previous button levels into track selection and run/stop control. It drives the `Timer` (count/reset), the sample-address machine (address reset) and the display path (track number, change pulse). It sits between the button front end and the Timer/address/Display blocks, in the same role `ASM_volume` plays for volume.

## Interface
Parameters:
- `N_TRACKS`, default 4: number of stored tracks; legal range 2..16.
- `RESTART_SEC`, default 3: elapsed-seconds threshold (0..9) for `prev` restart-versus-previous.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `play_pause` in 1: button level, already synchronous to `clk` and debounced.
- `next` in 1: button level.
- `prev` in 1: button level.
- `track_end` in 1: one-cycle pulse from the address machine on the last sample of the track.
- `seconds0` in 4: BCD elapsed seconds, units digit, from Timer.
- `seconds1` in 4: BCD elapsed seconds, tens digit.
- `minutes0` in 4: BCD elapsed minutes.
- `music` out 4: current track index, 0..N_TRACKS-1, feeds Display and address base.
- `timer_count` out 1: Timer count enable.
- `timer_reset` out 1: Timer reset pulse.
- `addr_reset` out 1: address machine reset pulse.
- `playing` out 1: high while in PLAY.
- `track_changed` out 1: one-cycle pulse, feeds display select logic.

## Operation
- Button edge detect: `x_q` is the previous-cycle level. An edge is `x & ~x_q`. `x_q` resets to 1, so a button held through reset release does not count as an edge.
- States:
  - STOP (reset state).
  - PLAY.
  - PAUSE.
  - LOAD: one-cycle transient.
  - `target` register (STOP/PLAY/PAUSE) selects the state LOAD exits to.
- Priority when several events occur in one cycle: `track_end` > `next` > `prev` > `play_pause`. Lower-priority edges in that cycle are discarded.
- STOP:
  - `play_pause` edge → LOAD, target PLAY, music unchanged.
  - `next`/`prev` → music ±1 (modulo N_TRACKS), LOAD, target STOP.
- PLAY:
  - `play_pause` → PAUSE.
  - `next` → music+1, wrapping N_TRACKS-1→0; LOAD, target PLAY.
  - `prev`:
    - If elapsed ≥ RESTART_SEC (minutes0≠0 or seconds1≠0 or seconds0≥RESTART_SEC), music unchanged (restart current track).
    - Otherwise music-1, wrapping 0→N_TRACKS-1.
    - Either way LOAD, target PLAY.
  - `track_end` → see Configuration.
- PAUSE:
  - `play_pause` → PLAY.
  - `next`/`prev` → same music rules as PLAY, LOAD, target PAUSE.
  - `track_end` ignored.
- LOAD: all inputs, including `track_end`, are ignored; edge registers still update. Exits to `target` on the next edge.
- Outputs, decoded from the registered state:
  - `timer_count` = `playing` = (state==PLAY).
  - `timer_reset` = `addr_reset` = `track_changed` = (state==LOAD).
- `music` is registered and updates on the same edge that enters LOAD.

## Timing
- Reset (`reset`=0, asynchronous): state STOP, target STOP, music 0, all outputs 0, edge registers 1.
- An edge sampled at rising edge k changes state at edge k. Outputs reflect the new state after edge k, with zero extra latency.
- Every track change spends exactly one cycle in LOAD. The timer/address reset pulse is therefore exactly 1 clk wide, and the new `music` value is stable during it.
- In PLAY, `timer_count` deasserts for the LOAD cycle, then reasserts.
- Holding a button produces only one action; a new action requires release for ≥1 cycle.
- Reset asserted mid-LOAD aborts it. No pulse completes beyond the reset assertion.

## Configuration
- `PLAYBACK_AUTO_ADVANCE_EN` defined, `track_end` in PLAY:
  - If music < N_TRACKS-1: music+1, LOAD, target PLAY.
  - If music == N_TRACKS-1: music 0, LOAD, target STOP (playlist ends).
- Undefined: `track_end` in PLAY → music unchanged, LOAD, target STOP (single-track play).

## Test plan
- Reset, then `play_pause` high for 25 cycles → one LOAD pulse; `timer_reset`=`addr_reset`=`track_changed`=1 for 1 cycle; then PLAY with `timer_count`=1 and `music`=0.
- PLAY at music 3 (N_TRACKS=4), `next` pulse → music 0, one LOAD cycle, back in PLAY; second `play_pause` → PAUSE with `timer_count`=0.
- PLAY at music 1:
  - Elapsed 0:05, `prev` → music stays 1 with LOAD.
  - Elapsed 0:02, `prev` → music 0.
  - From music 0 with elapsed 0:00, `prev` → music 3.
- `track_end` pulse in PLAY at music 3:
  - With `PLAYBACK_AUTO_ADVANCE_EN`: music 0, final state STOP.
  - At music 1 with the macro: music 2, state PLAY.
  - Without the macro: music 1, state STOP.
- Same-cycle `track_end`+`next`+`play_pause` in PLAY at music 0 with the macro → only track_end acts; music 1, PLAY. `next` asserted during the LOAD cycle is ignored.
- Assert `reset` low during the LOAD cycle → outputs 0 immediately, music 0, STOP; button held through release produces no action.
